load_store_unit: RTL

- Sits between the single-cycle core's data-memory port (Addr/WriteData/MemWrite/ReadData) and a handshaked, variable-latency data memory.
- Adds sub-word access (lb, lh, lw, lbu, lhu, sb, sh) with byte enables, lane alignment and load extension.
- Stalls the core until the access completes. Next step beyond the fixed-latency word-only dmem.

---
 rtl/load_store_unit.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store unit bridging a single-cycle core to a handshaked, variable-latency data memory.
// Optional bus timeout abort is compiled in with `define BUS_TIMEOUT_EN.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        AccessErr,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [3:0]  MemBe,
  output logic [31:0] MemWData,
  input  logic        MemGnt,
  input  logic        MemRValid,
  input  logic [31:0] MemRData
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  lane_q, lane_d;

  logic        req, is_wr, f3_ok, align_ok, legal;
  logic [3:0]  be_new;
  logic [31:0] wdata_new, ld_shift, ld_val;
  logic [15:0] ld_half;
  logic        timeout;

`ifdef BUS_TIMEOUT_EN
  logic [31:0] cnt_q, cnt_d;
  assign timeout = (cnt_q >= (TIMEOUT_CYCLES - 32'd1));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  assign req   = MemRead | MemWrite;
  assign is_wr = MemWrite;  // read+write together is treated as a write

  always_comb begin
    f3_ok    = is_wr ? (Funct3 inside {3'b000, 3'b001, 3'b010})
                     : !(Funct3 inside {3'b011, 3'b110, 3'b111});
    align_ok = 1'b1;
    case (Funct3[1:0])
      2'b01:   align_ok = ~Addr[0];
      2'b10:   align_ok = (Addr[1:0] == 2'b00);
      default: align_ok = 1'b1;
    endcase
    legal = f3_ok & align_ok;

    be_new    = 4'b1111;
    wdata_new = 32'd0;
    if (is_wr) begin
      case (Funct3[1:0])
        2'b00: begin
          be_new    = 4'b0001 << Addr[1:0];
          wdata_new = {4{WriteData[7:0]}};
        end
        2'b01: begin
          be_new    = 4'b0011 << {Addr[1], 1'b0};
          wdata_new = {2{WriteData[15:0]}};
        end
        default: begin
          be_new    = 4'b1111;
          wdata_new = WriteData;
        end
      endcase
    end
  end

  // Extraction uses the lane/size captured at request time.
  always_comb begin
    ld_shift = MemRData >> {lane_q, 3'b000};
    ld_half  = lane_q[1] ? MemRData[31:16] : MemRData[15:0];
    case (f3_q)
      3'b000:  ld_val = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_val = {24'd0, ld_shift[7:0]};
      3'b101:  ld_val = {16'd0, ld_half};
      default: ld_val = MemRData;
    endcase
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    f3_d    = f3_q;
    lane_d  = lane_q;
`ifdef BUS_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (req) begin
          if (legal) begin
            state_d = StReq;
            we_d    = is_wr;
            addr_d  = {Addr[31:2], 2'b00};
            be_d    = be_new;
            wdata_d = wdata_new;
            f3_d    = Funct3;
            lane_d  = Addr[1:0];
`ifdef BUS_TIMEOUT_EN
            cnt_d   = 32'd0;
`endif
          end else begin
            state_d = StDone;
            err_d   = 1'b1;
            rdata_d = 32'd0;
          end
        end
      end
      StReq: begin
`ifdef BUS_TIMEOUT_EN
        cnt_d = cnt_q + 32'd1;
`endif
        if (MemGnt) begin
          if (we_q) begin
            state_d = StDone;
            rdata_d = 32'd0;
          end else begin
            state_d = StWait;
          end
        end else if (timeout) begin
          state_d = StDone;
          err_d   = 1'b1;
          rdata_d = 32'd0;
        end
      end
      StWait: begin
`ifdef BUS_TIMEOUT_EN
        cnt_d = cnt_q + 32'd1;
`endif
        if (MemRValid) begin
          state_d = StDone;
          rdata_d = ld_val;
        end else if (timeout) begin
          state_d = StDone;
          err_d   = 1'b1;
          rdata_d = 32'd0;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      be_q    <= 4'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      f3_q    <= 3'd0;
      lane_q  <= 2'd0;
`ifdef BUS_TIMEOUT_EN
      cnt_q   <= 32'd0;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      f3_q    <= f3_d;
      lane_q  <= lane_d;
`ifdef BUS_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // err_q is only set on the edge entering DONE, so it is high exactly in DONE.
  assign Stall     = req & (state_q != StDone) & ~reset;
  assign AccessErr = err_q;
  assign MemReq    = (state_q == StReq);
  assign MemWe     = we_q;
  assign MemAddr   = addr_q;
  assign MemBe     = be_q;
  assign MemWData  = wdata_q;
  assign ReadData  = rdata_q;

endmodule
